// File: rtl/voice_alloc_if.sv
// Command/result bundle between the MIDI front end and voice_alloc.
// The scheduler attaches to the slave modport; the driver of commands uses master.
interface voice_alloc_if #(
  parameter int N = 75
);
  logic         note_on;
  logic         note_off;
  logic [6:0]   note;
  logic [N-1:0] voice_free;
  logic         busy;
  logic [N-1:0] start_out;
  logic [N-1:0] stop_out;
  logic [6:0]   alloc_voice;
  logic         stolen;
  logic         dropped;

  modport master (
    output note_on, note_off, note, voice_free,
    input  busy, start_out, stop_out, alloc_voice, stolen, dropped
  );

  modport slave (
    input  note_on, note_off, note, voice_free,
    output busy, start_out, stop_out, alloc_voice, stolen, dropped
  );
endinterface

// File: rtl/voice_alloc.sv
// Note-to-voice scheduler: one voice examined per clock, then start/stop pulses issued.
// Define VOICE_STEAL_EN to steal the oldest busy voice when the whole bank is occupied.
module voice_alloc #(
  parameter int N     = 75,
  parameter int AGE_W = 8
) (
  input  logic         MHz10,
  input  logic         nrst,
  input  logic         en,
  input  logic         clear,
  voice_alloc_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, STOP, ISSUE} state_t;

`ifdef VOICE_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif

  state_t       state_q, state_d;
  logic [6:0]   idx_q, idx_d;
  logic         op_on_q, op_on_d;
  logic [6:0]   note_q, note_d;
  logic         mfound_q, mfound_d, ffound_q, ffound_d;
  logic [6:0]   match_q, match_d, free_q, free_d;
  logic         pend_q, pend_d, pend_on_q, pend_on_d;
  logic [6:0]   pend_note_q, pend_note_d;
  logic [6:0]   alloc_q, alloc_d;
  logic [N-1:0] tvalid_q, tvalid_d;
  logic [6:0]   tag_q [N];

`ifdef VOICE_STEAL_EN
  logic             ofound_q, ofound_d;
  logic [6:0]       old_q, old_d;
  logic [AGE_W-1:0] oage_q, oage_d;
  logic [AGE_W-1:0] seq_q, seq_d;
  logic [AGE_W-1:0] stamp_q [N];
  logic [AGE_W-1:0] age;
  assign age = seq_q - stamp_q[idx_q];
`endif

  logic act, cmd, cmd_on, last, launch;
  logic do_start, do_stop, do_steal, miss, fire_start, fire_off;
  logic [6:0]   tgt;
  logic [N-1:0] onehot;

  assign act    = en && !clear;
  assign cmd    = act && (bus.note_on || bus.note_off);
  assign cmd_on = bus.note_on && !bus.note_off;
  assign last   = (idx_q == 7'(N - 1));

  // Action chosen once the scan has seen every voice
  always_comb begin
    tgt      = match_q;
    do_start = 1'b0;
    do_stop  = 1'b0;
    do_steal = 1'b0;
    miss     = 1'b0;
    if (op_on_q) begin
      if (mfound_q) begin
        do_start = 1'b1;
      end else if (ffound_q) begin
        tgt      = free_q;
        do_start = 1'b1;
      end else begin
`ifdef VOICE_STEAL_EN
        tgt      = old_q;
        do_start = 1'b1;
        do_steal = 1'b1;
`else
        miss     = 1'b1;
`endif
      end
    end else begin
      do_stop = mfound_q;
    end
  end

  assign onehot     = {{(N-1){1'b0}}, 1'b1} << tgt;
  assign fire_start = act && (state_q == ISSUE) && do_start;
  assign fire_off   = act && (state_q == ISSUE) && do_stop;

  assign bus.busy        = (state_q != IDLE);
  assign bus.start_out   = fire_start ? onehot : '0;
  assign bus.stop_out    = ((act && state_q == STOP) || fire_off) ? onehot : '0;
  assign bus.stolen      = act && (state_q == ISSUE) && do_steal;
  assign bus.dropped     = (act && bus.note_on && bus.note_off)
                        || (cmd && pend_q && state_q != IDLE)
                        || (act && state_q == ISSUE && miss);
  assign bus.alloc_voice = fire_start ? tgt : alloc_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    op_on_d     = op_on_q;
    note_d      = note_q;
    mfound_d    = mfound_q;
    match_d     = match_q;
    ffound_d    = ffound_q;
    free_d      = free_q;
    pend_d      = pend_q;
    pend_on_d   = pend_on_q;
    pend_note_d = pend_note_q;
    tvalid_d    = tvalid_q;
    alloc_d     = alloc_q;
    launch      = 1'b0;
`ifdef VOICE_STEAL_EN
    ofound_d    = ofound_q;
    old_d       = old_q;
    oage_d      = oage_q;
    seq_d       = seq_q;
`endif
    if (act) begin
      case (state_q)
        IDLE: begin
          // The slot is older than anything arriving now, so it goes first
          if (pend_q) begin
            launch      = 1'b1;
            op_on_d     = pend_on_q;
            note_d      = pend_note_q;
            pend_d      = cmd;
            pend_on_d   = cmd_on;
            pend_note_d = bus.note;
          end else if (cmd) begin
            launch  = 1'b1;
            op_on_d = cmd_on;
            note_d  = bus.note;
          end
        end
        SCAN: begin
          if (!mfound_q && tvalid_q[idx_q] && tag_q[idx_q] == note_q) begin
            mfound_d = 1'b1;
            match_d  = idx_q;
          end
          if (!ffound_q && bus.voice_free[idx_q]) begin
            ffound_d = 1'b1;
            free_d   = idx_q;
          end
`ifdef VOICE_STEAL_EN
          if (!bus.voice_free[idx_q] && (!ofound_q || age > oage_q)) begin
            ofound_d = 1'b1;
            old_d    = idx_q;
            oage_d   = age;
          end
`endif
          idx_d = idx_q + 7'd1;
          if (last)
            state_d = (op_on_q && (mfound_d || (!ffound_d && STEAL))) ? STOP : ISSUE;
        end
        STOP:    state_d = ISSUE;
        default: state_d = IDLE;
      endcase
      if (state_q != IDLE && cmd && !pend_q) begin
        pend_d      = 1'b1;
        pend_on_d   = cmd_on;
        pend_note_d = bus.note;
      end
      if (launch) begin
        state_d  = SCAN;
        idx_d    = '0;
        mfound_d = 1'b0;
        ffound_d = 1'b0;
`ifdef VOICE_STEAL_EN
        ofound_d = 1'b0;
`endif
      end
      if (fire_start) begin
        tvalid_d[tgt] = 1'b1;
        alloc_d       = tgt;
`ifdef VOICE_STEAL_EN
        seq_d         = seq_q + 1'b1;
`endif
      end
      if (fire_off) tvalid_d[tgt] = 1'b0;
    end
    if (clear) begin
      state_d  = IDLE;
      pend_d   = 1'b0;
      tvalid_d = '0;
      alloc_d  = '0;
`ifdef VOICE_STEAL_EN
      seq_d    = '0;
`endif
    end
  end

  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      op_on_q   <= 1'b0;
      mfound_q  <= 1'b0;
      ffound_q  <= 1'b0;
      pend_q    <= 1'b0;
      pend_on_q <= 1'b0;
      tvalid_q  <= '0;
      alloc_q   <= '0;
`ifdef VOICE_STEAL_EN
      ofound_q  <= 1'b0;
      seq_q     <= '0;
      for (int i = 0; i < N; i++) stamp_q[i] <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      op_on_q   <= op_on_d;
      mfound_q  <= mfound_d;
      ffound_q  <= ffound_d;
      pend_q    <= pend_d;
      pend_on_q <= pend_on_d;
      tvalid_q  <= tvalid_d;
      alloc_q   <= alloc_d;
`ifdef VOICE_STEAL_EN
      ofound_q  <= ofound_d;
      seq_q     <= seq_d;
      if (clear) begin
        for (int i = 0; i < N; i++) stamp_q[i] <= '0;
      end else if (fire_start) begin
        stamp_q[tgt] <= seq_q;
      end
`endif
    end
  end

  // Datapath registers carry no reset; control flags qualify them
  always_ff @(posedge MHz10) begin
    note_q      <= note_d;
    match_q     <= match_d;
    free_q      <= free_d;
    pend_note_q <= pend_note_d;
`ifdef VOICE_STEAL_EN
    old_q       <= old_d;
    oage_q      <= oage_d;
`endif
    if (fire_start) tag_q[tgt] <= note_q;
  end
endmodule

// File: tb/tb_voice_alloc.sv
// Bench for voice_alloc: directed scenarios plus a random command stream, all
// compared against a per-voice table model of note ownership and allocation age.
module tb_voice_alloc;
  localparam int N = 75;

  logic MHz10 = 1'b0;
  logic nrst  = 1'b0;
  logic en    = 1'b1;
  logic clear = 1'b0;

  voice_alloc_if #(.N(N)) bus ();

  voice_alloc #(.N(N), .AGE_W(8)) dut (
    .MHz10 (MHz10),
    .nrst  (nrst),
    .en    (en),
    .clear (clear),
    .bus   (bus)
  );

  always #5 MHz10 = ~MHz10;

  int n_tests = 0;
  int n_fail  = 0;

  int m_tag   [N];
  bit m_valid [N];
  int m_stamp [N];
  int m_seq;
  int m_alloc;

  logic [N-1:0] l_stop_v;
  int l_stolen_c, l_drop_c, l_nstart;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int v);
    logic [N-1:0] r;
    r = '0;
    if (v >= 0) r[v] = 1'b1;
    return r;
  endfunction

  task automatic m_reset();
    for (int v = 0; v < N; v++) begin
      m_valid[v] = 0;
      m_stamp[v] = 0;
      m_tag[v]   = 0;
    end
    m_seq   = 0;
    m_alloc = 0;
  endtask

  // Expected pulse cycles are counted from the accept cycle; -1 means none.
  task automatic predict(input bit on, input int nt, input logic [N-1:0] vf, input int pause,
                         output int e_stop, output int e_start, output int e_stolen,
                         output int e_drop, output int e_end, output int ev);
    int m, f, base;
`ifdef VOICE_STEAL_EN
    int o, best, age;
    o = -1;
    best = -1;
`endif
    m = -1;
    f = -1;
    for (int v = 0; v < N; v++) begin
      if (m < 0 && m_valid[v] && m_tag[v] == nt) m = v;
      if (f < 0 && vf[v]) f = v;
`ifdef VOICE_STEAL_EN
      if (!vf[v]) begin
        age = (m_seq - m_stamp[v]) & 255;
        if (age > best) begin best = age; o = v; end
      end
`endif
    end
    base = N + 1 + pause;
    e_stop = -1; e_start = -1; e_stolen = -1; e_drop = -1; e_end = base + 1; ev = -1;
    if (!on) begin
      if (m >= 0) begin e_stop = base; ev = m; m_valid[m] = 0; end
    end else if (m >= 0) begin
      e_stop = base; e_start = base + 1; e_end = base + 2; ev = m;
    end else if (f >= 0) begin
      e_start = base; ev = f;
    end else begin
`ifdef VOICE_STEAL_EN
      e_stop = base; e_start = base + 1; e_stolen = base + 1; e_end = base + 2; ev = o;
`else
      e_drop = base;
`endif
    end
    if (e_start >= 0) begin
      m_tag[ev]   = nt;
      m_valid[ev] = 1;
      m_stamp[ev] = m_seq;
      m_seq       = (m_seq + 1) % 256;
      m_alloc     = ev;
    end
  endtask

  task automatic run_cmd(input bit on, input int nt, input logic [N-1:0] vf, input int pause,
                         input string nm);
    int e_stop, e_start, e_stolen, e_drop, e_end, ev;
    int c_stop, c_start, c_stolen, c_drop, c_end, nstart;
    logic [N-1:0] v_stop, v_start;
    predict(on, nt, vf, pause, e_stop, e_start, e_stolen, e_drop, e_end, ev);
    @(negedge MHz10);
    bus.voice_free = vf;
    bus.note       = 7'(nt);
    bus.note_on    = on;
    bus.note_off   = !on;
    c_stop = -1; c_start = -1; c_stolen = -1; c_drop = -1; c_end = -1; nstart = 0;
    v_stop = '0; v_start = '0;
    for (int j = 1; j <= N + 4 + pause; j++) begin
      @(posedge MHz10);
      #1;
      if (j == 1) begin bus.note_on = 1'b0; bus.note_off = 1'b0; end
      @(negedge MHz10);
      if (j == 1) check({nm, " busy_start"}, bus.busy, 1);
      if (bus.start_out != 0) begin
        nstart++;
        if (c_start < 0) begin c_start = j; v_start = bus.start_out; end
      end
      if (bus.stop_out != 0 && c_stop < 0) begin c_stop = j; v_stop = bus.stop_out; end
      if (bus.stolen && c_stolen < 0) c_stolen = j;
      if (bus.dropped && c_drop < 0) c_drop = j;
      if (!bus.busy && c_end < 0) c_end = j;
      if (pause > 0 && j == 10) en = 1'b0;
      if (pause > 0 && j == 10 + pause) en = 1'b1;
    end
    check({nm, " start_cyc"}, c_start, e_start);
    check({nm, " start_vec"}, v_start, (e_start >= 0) ? onehot(ev) : '0);
    check({nm, " start_cnt"}, nstart, (e_start >= 0) ? 1 : 0);
    check({nm, " stop_cyc"}, c_stop, e_stop);
    check({nm, " stop_vec"}, v_stop, (e_stop >= 0) ? onehot(ev) : '0);
    check({nm, " stolen_cyc"}, c_stolen, e_stolen);
    check({nm, " drop_cyc"}, c_drop, e_drop);
    check({nm, " busy_end"}, c_end, e_end);
    check({nm, " alloc"}, bus.alloc_voice, m_alloc);
    l_stop_v = v_stop; l_stolen_c = c_stolen; l_drop_c = c_drop; l_nstart = nstart;
  endtask

  initial begin
    logic [N-1:0] all1, vf;
    int a_stop, a_start, a_stolen, a_drop, a_end, a_v;
    int b_stop, b_start, b_stolen, b_drop, b_end, b_v;
    int sq[$], sv[$], dq[$];
    int nst;
    all1 = '1;
    bus.note_on = 1'b0; bus.note_off = 1'b0; bus.note = '0; bus.voice_free = all1;
    m_reset();
    repeat (3) @(negedge MHz10);
    check("rst busy", bus.busy, 0);
    check("rst start", bus.start_out, 0);
    check("rst stop", bus.stop_out, 0);
    check("rst alloc", bus.alloc_voice, 0);
    check("rst stolen", bus.stolen, 0);
    check("rst dropped", bus.dropped, 0);
    nrst = 1'b1;

    run_cmd(1, 60, all1, 0, "on60");
    vf = all1; vf[0] = 1'b0;
    run_cmd(0, 60, vf, 0, "off60");
    run_cmd(0, 60, vf, 0, "off60_again");
    run_cmd(1, 60, all1, 0, "on60_b");
    run_cmd(1, 60, vf, 0, "retrig60");
    run_cmd(1, 61, vf, 5, "en_pause");

    // Reset asserted in the middle of a scan
    @(negedge MHz10);
    bus.note = 7'd33; bus.note_on = 1'b1;
    @(posedge MHz10); #1 bus.note_on = 1'b0;
    repeat (9) @(negedge MHz10);
    nrst = 1'b0;
    #1;
    check("nrst_mid busy", bus.busy, 0);
    check("nrst_mid pulses", {bus.start_out, bus.stop_out, bus.stolen, bus.dropped}, 0);
    check("nrst_mid alloc", bus.alloc_voice, 0);
    @(negedge MHz10);
    nrst = 1'b1;
    m_reset();
    run_cmd(1, 45, all1, 0, "after_nrst");

    // Clear in the middle of a scan
    @(negedge MHz10);
    bus.note = 7'd40; bus.note_on = 1'b1; bus.voice_free = all1;
    @(posedge MHz10); #1 bus.note_on = 1'b0;
    repeat (9) @(negedge MHz10);
    clear = 1'b1;
    @(posedge MHz10); #1 clear = 1'b0;
    @(negedge MHz10);
    check("clear_mid busy", bus.busy, 0);
    nst = 0;
    for (int j = 0; j < N + 4; j++) begin
      @(negedge MHz10);
      if (bus.start_out != 0) nst++;
    end
    check("clear_mid starts", nst, 0);
    check("clear_mid alloc", bus.alloc_voice, 0);
    m_reset();

    // Three back-to-back note_on: served, queued, dropped
    predict(1, 20, all1, 0, a_stop, a_start, a_stolen, a_drop, a_end, a_v);
    predict(1, 21, all1, 0, b_stop, b_start, b_stolen, b_drop, b_end, b_v);
    @(negedge MHz10);
    bus.voice_free = all1; bus.note = 7'd20; bus.note_on = 1'b1;
    for (int j = 1; j <= a_end + b_end + 2; j++) begin
      @(posedge MHz10);
      #1;
      if (j == 1) bus.note = 7'd21;
      if (j == 2) bus.note = 7'd22;
      if (j == 3) bus.note_on = 1'b0;
      @(negedge MHz10);
      if (bus.start_out != 0) begin
        sq.push_back(j);
        for (int v = 0; v < N; v++) if (bus.start_out[v]) sv.push_back(v);
      end
      if (bus.dropped) dq.push_back(j);
    end
    check("queue n_start", sq.size(), 2);
    if (sq.size() >= 2) begin
      check("queue start1_cyc", sq[0], a_start);
      check("queue start2_cyc", sq[1], a_end + b_start);
    end
    if (sv.size() >= 2) begin
      check("queue start1_v", sv[0], a_v);
      check("queue start2_v", sv[1], b_v);
    end
    check("queue n_drop", dq.size(), 1);
    if (dq.size() >= 1) check("queue drop_cyc", dq[0], 2);

    // Fill the whole bank, voice 5 first, then strike a new note
    @(negedge MHz10);
    clear = 1'b1;
    @(negedge MHz10);
    clear = 1'b0;
    m_reset();
    run_cmd(1, 5, onehot(5), 0, "fill5");
    for (int v = 0; v < N; v++) begin
      if (v != 5) run_cmd(1, (v < 72) ? v : v + 1, onehot(v), 0, "fill");
    end
    run_cmd(1, 72, '0, 0, "full72");
`ifdef VOICE_STEAL_EN
    check("full72 victim", l_stop_v, onehot(5));
    check("full72 stolen", l_stolen_c, N + 2);
`else
    check("full72 dropped", l_drop_c, N + 1);
    check("full72 no_start", l_nstart, 0);
`endif

    // Random command stream
    for (int k = 0; k < 60; k++) begin
      int r;
      r = $urandom_range(0, 3);
      if (r == 0) vf = '0;
      else if (r == 1) vf = onehot($urandom_range(0, N - 1));
      else for (int v = 0; v < N; v++) vf[v] = ($urandom_range(0, 15) == 0);
      run_cmd(($urandom_range(0, 9) < 6), 60 + $urandom_range(0, 5), vf, 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/voice_alloc.md
Name: voice_alloc

Overview:
Note-to-voice scheduler between midi_decoder and the saw_counter bank; replaces the simple first-free start_arbitrator.
- Tracks which MIDI note each oscillator voice holds.
- Routes a note-off to the voice holding that note.
- Re-triggers a voice when its note is struck again.
- Steals the oldest voice when every voice is busy.
- Scans one voice per clock, so the 75-voice bank needs no wide parallel comparators.

Parameters:
N, 75, number of oscillator voices (2..127)
AGE_W, 8, width of the allocation sequence counter and of each per-voice stamp

Ports:
MHz10  input  1  system clock (10 MHz)
nrst  input  1  asynchronous active-low reset
en  input  1  chip enable; low freezes all state and forces pulse outputs to 0
clear  input  1  synchronous flush of all tracking state
note_on  input  1  one-cycle pulse: note-on command
note_off  input  1  one-cycle pulse: note-off command
note  input  7  MIDI note number, sampled with note_on/note_off
voice_free  input  N  per-voice available flag from the oscillators
busy  output  1  scan in progress
start_out  output  N  one-hot, one-cycle start pulse to a voice
stop_out  output  N  one-hot, one-cycle end pulse to a voice
alloc_voice  output  7  index of the voice chosen by the last note_on
stolen  output  1  one-cycle pulse when a busy voice is taken
dropped  output  1  one-cycle pulse when a command is discarded

Behaviour:
- Reset (nrst=0, async) and clear (sync) both give:
  - FSM in IDLE; all outputs 0; alloc_voice=0.
  - All tag_valid=0, all stamps=0, seq=0, pending slot empty.
- Per-voice state: tag[7], tag_valid, stamp[AGE_W]. Global state: seq[AGE_W], which wraps modulo 2^AGE_W.
- Commands are accepted only when en=1.
  - If note_on and note_off are both high, note_off wins and dropped pulses.
- Pending slot (1 deep):
  - A command arriving while busy=1 is stored in the slot.
  - If the slot is already full, the new command is discarded and dropped pulses.
  - In IDLE the slot is served before any new input; same-cycle new input is then stored in the slot.
- FSM states: IDLE -> SCAN -> (STOP) -> ISSUE -> IDLE.
- IDLE: on accept, latch the op and note, set idx=0, go to SCAN. busy is high from the next cycle.
- SCAN: examines voice idx for one cycle, for idx = 0..N-1 (N cycles), tracking:
  - match: the lowest idx with tag_valid and tag==note.
  - free: the lowest idx with voice_free=1.
  - oldest: the voice with voice_free=0 and maximum (seq - stamp) mod 2^AGE_W; ties go to the lowest idx.
- After the last idx, the decision is:
  - note_off, match found: stop_out[match] pulses in ISSUE and tag_valid[match] is cleared.
  - note_off, no match: nothing is issued.
  - note_on, match found (re-trigger): stop_out[match] pulses in STOP, start_out[match] pulses in ISSUE.
  - note_on, no match, free found: start_out[free] pulses in ISSUE.
  - note_on, no match, no free voice: handled per VOICE_STEAL_EN. With stealing: stop_out[oldest] in STOP, start_out[oldest] and stolen in ISSUE.
- On every start_out[v] (same cycle):
  - tag[v]=note, tag_valid[v]=1, stamp[v]=seq, alloc_voice=v.
  - seq increments.
- Latency from the accept cycle T:
  - Plain start or stop pulse at T+N+1.
  - STOP path: stop pulse at T+N+1, start pulse at T+N+2.
  - busy deasserts in the cycle after ISSUE.
- en=0 mid-scan: state is held and pulses are suppressed; the scan resumes when en returns.
- clear mid-scan: abort to IDLE with no pulse.
- voice_free changing during a scan: only the value sampled at each idx's visit counts.

Optional Feature:
VOICE_STEAL_EN
- Defined: a full bank steals the oldest busy voice as described above.
- Undefined: a note_on with no match and no free voice issues nothing, pulses dropped, and leaves seq unchanged. The oldest-tracking logic is not built.

Test Plan:
- All voice_free=1; note_on note=60 -> start_out[0] pulses at T+76; alloc_voice=0; tag[0]=60.
- After the above, voice_free[0]=0; note_off note=60 -> stop_out[0] pulses at T+76; a second note_off 60 -> no pulse.
- voice_free[0]=0 with tag 60; note_on 60 -> stop_out[0] at T+76, start_out[0] at T+77, no stolen.
- VOICE_STEAL_EN, all 75 voices busy, voice 5 allocated first -> note_on 72 gives stop_out[5], then start_out[5] plus stolen. Without the macro -> dropped only.
- Three note_on pulses 1 cycle apart while idle -> first served, second queued and served next, third gives dropped.
- Assert nrst mid-scan -> busy=0, all outputs 0 immediately. clear mid-scan -> IDLE next cycle, no start_out.
